// File: rtl/chip8_fb_pkg.sv
// Shared framebuffer geometry, blitter state encoding and word-address helper.
package chip8_fb_pkg;

   localparam int FB_ROWS          = 64;
   localparam int FB_WORDS_PER_ROW = 8;
   localparam int FB_ADDR_W        = 9;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LATCH = 3'd2;
   localparam logic [2:0] ST_RD    = 3'd3;
   localparam logic [2:0] ST_WR    = 3'd4;
   localparam logic [2:0] ST_NEXT  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      FETCH = ST_FETCH,
      LATCH = ST_LATCH,
      RD    = ST_RD,
      WR    = ST_WR,
      NEXT  = ST_NEXT,
      DONE  = ST_DONE
   } state_t;

   function automatic logic [FB_ADDR_W-1:0] fb_word_addr(input logic [5:0] row,
                                                         input logic [2:0] word);
      return {row, word};
   endfunction

endpackage

// File: rtl/sprite_row_align.sv
// Aligns one sprite row (8 or 16 pixels) to the pixel X offset within a
// 16-pixel word pair; mask_a covers the left word, mask_b the right one.
module sprite_row_align (
   input  logic [7:0]  hi_byte,
   input  logic [7:0]  lo_byte,
   input  logic        wide,
   input  logic [3:0]  shift,
   output logic [15:0] mask_a,
   output logic [15:0] mask_b
);
   logic [31:0] row_bits;

   assign row_bits = {hi_byte, (wide ? lo_byte : 8'h00), 16'h0000} >> shift;
   assign mask_a   = row_bits[31:16];
   assign mask_b   = row_bits[15:0];

endmodule

// File: rtl/sprite_blitter.sv
// Chip-8/SCHIP DXYN sprite draw engine: fetch, align, XOR read-modify-write.
// Define SPRITE_WRAP_EN to wrap rows and the right word instead of clipping.
module sprite_blitter #(
   parameter int FB_ADDR_W  = 9,
   parameter int SPR_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [6:0]            pos_x,
   input  logic [5:0]            pos_y,
   input  logic [3:0]            rows,
   output logic                  spr_rd,
   output logic [SPR_ADDR_W-1:0] spr_addr,
   input  logic [7:0]            spr_data,
   output logic                  fbuf_en,
   output logic                  fbuf_write,
   output logic [FB_ADDR_W-1:0]  fbuf_addr,
   output logic [15:0]           fbuf_in,
   input  logic [15:0]           fbuf_out,
   output logic                  busy,
   output logic                  done,
   output logic                  collision
);
   import chip8_fb_pkg::*;

   state_t      state_reg, state_next;
   logic [6:0]  px_reg, px_next;
   logic [5:0]  py_reg, py_next;
   logic [3:0]  last_row_reg, last_row_next;
   logic        wide_reg, wide_next;
   logic [3:0]  row_reg, row_next;
   logic        bsel_reg, bsel_next;
   logic [7:0]  left_reg, left_next;
   logic [15:0] mask_a_reg, mask_a_next;
   logic [15:0] mask_b_reg, mask_b_next;
   logic        wsel_reg, wsel_next;
   logic        collision_reg, collision_next;

   logic [15:0] al_a, al_b;
   logic [2:0]  word_a, word_b, cur_word;
   logic [5:0]  cur_y;
   logic [15:0] cur_mask;
   logic        b_allowed, next_clipped, last_row;

   sprite_row_align u_align (
      .hi_byte (wide_reg ? left_reg : spr_data),
      .lo_byte (spr_data),
      .wide    (wide_reg),
      .shift   (px_reg[3:0]),
      .mask_a  (al_a),
      .mask_b  (al_b)
   );

   assign word_a   = px_reg[6:4];
   assign word_b   = word_a + 3'd1;
   assign cur_word = wsel_reg ? word_b : word_a;
   assign cur_mask = wsel_reg ? mask_b_reg : mask_a_reg;
   assign cur_y    = py_reg + {2'b00, row_reg};

`ifdef SPRITE_WRAP_EN
   assign b_allowed    = 1'b1;
   assign next_clipped = 1'b0;
`else
   logic [6:0] next_y;
   assign next_y       = {1'b0, py_reg} + {3'b000, row_reg} + 7'd1;
   assign b_allowed    = (word_a != 3'd7);
   assign next_clipped = next_y[6];
`endif

   assign last_row  = (row_reg == last_row_reg) || next_clipped;
   assign collision = collision_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         px_reg        <= '0;
         py_reg        <= '0;
         last_row_reg  <= '0;
         wide_reg      <= 1'b0;
         row_reg       <= '0;
         bsel_reg      <= 1'b0;
         left_reg      <= '0;
         mask_a_reg    <= '0;
         mask_b_reg    <= '0;
         wsel_reg      <= 1'b0;
         collision_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         px_reg        <= px_next;
         py_reg        <= py_next;
         last_row_reg  <= last_row_next;
         wide_reg      <= wide_next;
         row_reg       <= row_next;
         bsel_reg      <= bsel_next;
         left_reg      <= left_next;
         mask_a_reg    <= mask_a_next;
         mask_b_reg    <= mask_b_next;
         wsel_reg      <= wsel_next;
         collision_reg <= collision_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      px_next        = px_reg;
      py_next        = py_reg;
      last_row_next  = last_row_reg;
      wide_next      = wide_reg;
      row_next       = row_reg;
      bsel_next      = bsel_reg;
      left_next      = left_reg;
      mask_a_next    = mask_a_reg;
      mask_b_next    = mask_b_reg;
      wsel_next      = wsel_reg;
      collision_next = collision_reg;
      spr_rd         = 1'b0;
      spr_addr       = '0;
      fbuf_en        = 1'b0;
      fbuf_write     = 1'b0;
      fbuf_addr      = '0;
      fbuf_in        = '0;
      busy           = (state_reg != IDLE);
      done           = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               px_next        = pos_x;
               py_next        = pos_y;
               // N=0 wraps to 15, i.e. 16 rows of a 16x16 sprite
               last_row_next  = rows - 4'd1;
               wide_next      = (rows == 4'd0);
               row_next       = '0;
               bsel_next      = 1'b0;
               collision_next = 1'b0;
               state_next     = FETCH;
            end
         end
         FETCH: begin
            spr_rd     = 1'b1;
            spr_addr   = wide_reg ? SPR_ADDR_W'({row_reg, bsel_reg}) : SPR_ADDR_W'(row_reg);
            state_next = LATCH;
         end
         LATCH: begin
            if (wide_reg && !bsel_reg) begin
               left_next  = spr_data;
               bsel_next  = 1'b1;
               state_next = FETCH;
            end else begin
               mask_a_next = al_a;
               mask_b_next = b_allowed ? al_b : 16'h0000;
               if (al_a != 16'h0000) begin
                  wsel_next  = 1'b0;
                  state_next = RD;
               end else if (mask_b_next != 16'h0000) begin
                  wsel_next  = 1'b1;
                  state_next = RD;
               end else begin
                  state_next = NEXT;
               end
            end
         end
         RD: begin
            fbuf_en    = 1'b1;
            fbuf_addr  = FB_ADDR_W'(fb_word_addr(cur_y, cur_word));
            state_next = WR;
         end
         WR: begin
            fbuf_en    = 1'b1;
            fbuf_write = 1'b1;
            fbuf_addr  = FB_ADDR_W'(fb_word_addr(cur_y, cur_word));
            fbuf_in    = fbuf_out ^ cur_mask;
            if ((fbuf_out & cur_mask) != 16'h0000)
               collision_next = 1'b1;
            if (!wsel_reg && (mask_b_reg != 16'h0000)) begin
               wsel_next  = 1'b1;
               state_next = RD;
            end else if (last_row) begin
               state_next = DONE;
            end else begin
               state_next = NEXT;
            end
         end
         NEXT: begin
            row_next  = row_reg + 4'd1;
            bsel_next = 1'b0;
            state_next = last_row ? DONE : FETCH;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed, table-driven bench for sprite_blitter with sprite ROM and framebuffer models.
module tb_sprite_blitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [6:0]  pos_x;
   logic [5:0]  pos_y;
   logic [3:0]  rows;
   logic        spr_rd;
   logic [4:0]  spr_addr;
   logic [7:0]  spr_data;
   logic        fbuf_en;
   logic        fbuf_write;
   logic [8:0]  fbuf_addr;
   logic [15:0] fbuf_in;
   logic [15:0] fbuf_out;
   logic        busy;
   logic        done;
   logic        collision;

   always #5 clk = ~clk;

   sprite_blitter #(.FB_ADDR_W(9), .SPR_ADDR_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .rows       (rows),
      .spr_rd     (spr_rd),
      .spr_addr   (spr_addr),
      .spr_data   (spr_data),
      .fbuf_en    (fbuf_en),
      .fbuf_write (fbuf_write),
      .fbuf_addr  (fbuf_addr),
      .fbuf_in    (fbuf_in),
      .fbuf_out   (fbuf_out),
      .busy       (busy),
      .done       (done),
      .collision  (collision)
   );

   // sprite memory and framebuffer models
   logic [7:0]  rom [32];
   logic [15:0] fb_mem [512];
   logic        clr_fb, clr_cnt;
   int          n_wr, n_rd;

   always @(posedge clk) begin
      if (clr_fb) begin
         for (int j = 0; j < 512; j++) fb_mem[j] <= 16'h0000;
      end else if (fbuf_en) begin
         if (fbuf_write) fb_mem[fbuf_addr] <= fbuf_in;
         else            fbuf_out <= fb_mem[fbuf_addr];
      end
      if (spr_rd) spr_data <= rom[spr_addr];
      if (clr_cnt) begin
         n_wr <= 0;
         n_rd <= 0;
      end else begin
         if (fbuf_en && fbuf_write) n_wr <= n_wr + 1;
         if (spr_rd) n_rd <= n_rd + 1;
      end
   end

   typedef struct {
      string             name;
      logic [6:0]        px;
      logic [5:0]        py;
      logic [3:0]        nrows;
      logic [7:0]        b_even;
      logic [7:0]        b_odd;
      bit                clear;
      int                cycles;
      int                writes;
      int                reads;
      logic              coll;
      logic [3:0][8:0]   a;
      logic [3:0][15:0]  d;
   } vec_t;

   vec_t vecs [8];
   int   n_checks = 0;
   int   n_errors = 0;

   logic        cap_en3, cap_wr3, cap_en4, cap_wr4;
   logic [8:0]  cap_addr4;
   logic [15:0] cap_in4;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [6:0] px, input logic [5:0] py,
                               input logic [3:0] nrows, input logic [7:0] be, input logic [7:0] bo,
                               input bit clear, input int cyc, input int wr, input int rd,
                               input logic coll,
                               input logic [8:0] a0, input logic [15:0] d0,
                               input logic [8:0] a1, input logic [15:0] d1,
                               input logic [8:0] a2, input logic [15:0] d2,
                               input logic [8:0] a3, input logic [15:0] d3);
      vec_t v;
      v.name = name; v.px = px; v.py = py; v.nrows = nrows;
      v.b_even = be; v.b_odd = bo; v.clear = clear;
      v.cycles = cyc; v.writes = wr; v.reads = rd; v.coll = coll;
      v.a[0] = a0; v.d[0] = d0; v.a[1] = a1; v.d[1] = d1;
      v.a[2] = a2; v.d[2] = d2; v.a[3] = a3; v.d[3] = d3;
      return v;
   endfunction

   task automatic run_vec(input int i);
      vec_t v;
      int   k;
      v = vecs[i];
      for (int j = 0; j < 32; j++) rom[j] = (j % 2 == 0) ? v.b_even : v.b_odd;
      @(negedge clk);
      clr_fb  = v.clear;
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_fb  = 1'b0;
      clr_cnt = 1'b0;
      pos_x = v.px; pos_y = v.py; rows = v.nrows;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (!done && k < 400) begin
         if (k == 3) begin cap_en3 = fbuf_en; cap_wr3 = fbuf_write; end
         if (k == 4) begin
            cap_en4 = fbuf_en; cap_wr4 = fbuf_write;
            cap_addr4 = fbuf_addr; cap_in4 = fbuf_in;
         end
         @(negedge clk);
         k++;
      end
      check({v.name, " latency"}, k, v.cycles);
      check({v.name, " done busy"}, {31'd0, busy}, 32'd1);
      check({v.name, " writes"}, n_wr, v.writes);
      check({v.name, " spr reads"}, n_rd, v.reads);
      check({v.name, " collision"}, {31'd0, collision}, {31'd0, v.coll});
      for (int j = 0; j < 4; j++)
         check($sformatf("%s word %0d", v.name, v.a[j]), {16'd0, fb_mem[v.a[j]]}, {16'd0, v.d[j]});
      $display("vec %0d %s: latency=%0d writes=%0d reads=%0d collision=%0b",
               i, v.name, k, n_wr, n_rd, collision);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pos_x = '0; pos_y = '0; rows = '0;
      clr_fb = 1'b1; clr_cnt = 1'b1;
      for (int j = 0; j < 32; j++) rom[j] = 8'h00;
      vecs[0] = mk("v0 aligned", 7'd0, 6'd0, 4'd1, 8'hF0, 8'hF0, 1, 5, 1, 1, 1'b0,
                   9'd0, 16'hF000, 9'd1, 16'h0000, 9'd8, 16'h0000, 9'd2, 16'h0000);
      vecs[1] = mk("v1 split", 7'd12, 6'd5, 4'd1, 8'hFF, 8'hFF, 1, 7, 2, 1, 1'b0,
                   9'd40, 16'h000F, 9'd41, 16'hF000, 9'd42, 16'h0000, 9'd48, 16'h0000);
      vecs[2] = mk("v2 redraw", 7'd12, 6'd5, 4'd1, 8'hFF, 8'hFF, 0, 7, 2, 1, 1'b1,
                   9'd40, 16'h0000, 9'd41, 16'h0000, 9'd42, 16'h0000, 9'd48, 16'h0000);
`ifdef SPRITE_WRAP_EN
      vecs[3] = mk("v3 corner", 7'd124, 6'd62, 4'd4, 8'hFF, 8'hFF, 1, 28, 8, 4, 1'b0,
                   9'd503, 16'h000F, 9'd496, 16'hF000, 9'd7, 16'h000F, 9'd0, 16'hF000);
`else
      vecs[3] = mk("v3 corner", 7'd124, 6'd62, 4'd4, 8'hFF, 8'hFF, 1, 10, 2, 2, 1'b0,
                   9'd503, 16'h000F, 9'd511, 16'h000F, 9'd496, 16'h0000, 9'd7, 16'h0000);
`endif
      vecs[4] = mk("v4 wide", 7'd0, 6'd0, 4'd0, 8'hFF, 8'h00, 1, 112, 16, 32, 1'b0,
                   9'd0, 16'hFF00, 9'd8, 16'hFF00, 9'd120, 16'hFF00, 9'd1, 16'h0000);
      vecs[5] = mk("v5 shift3", 7'd3, 6'd10, 4'd2, 8'h81, 8'h3C, 1, 10, 2, 2, 1'b0,
                   9'd80, 16'h1020, 9'd88, 16'h0780, 9'd81, 16'h0000, 9'd96, 16'h0000);
      vecs[6] = mk("v6 partial hit", 7'd3, 6'd10, 4'd1, 8'h01, 8'h01, 0, 5, 1, 1, 1'b1,
                   9'd80, 16'h1000, 9'd88, 16'h0780, 9'd81, 16'h0000, 9'd72, 16'h0000);
      vecs[7] = mk("v7 blank row", 7'd8, 6'd0, 4'd1, 8'h00, 8'h00, 1, 4, 0, 1, 1'b0,
                   9'd0, 16'h0000, 9'd1, 16'h0000, 9'd8, 16'h0000, 9'd9, 16'h0000);

      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset spr_rd", {31'd0, spr_rd}, 32'd0);
      check("reset fbuf_en", {31'd0, fbuf_en}, 32'd0);
      check("reset fbuf_write", {31'd0, fbuf_write}, 32'd0);
      check("reset collision", {31'd0, collision}, 32'd0);
      check("reset addr/data", {spr_addr, fbuf_addr, fbuf_in}, 32'd0);
      rst_n = 1'b1; clr_fb = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(i);
         if (i == 0) begin
            check("v0 RD en at T+3", {30'd0, cap_en3, cap_wr3}, 32'd2);
            check("v0 WR en at T+4", {30'd0, cap_en4, cap_wr4}, 32'd3);
            check("v0 WR addr", {23'd0, cap_addr4}, 32'd0);
            check("v0 WR data", {16'd0, cap_in4}, 32'h0000F000);
         end
         if (i == 2) begin
            repeat (5) @(negedge clk);
            check("collision held", {31'd0, collision}, 32'd1);
            check("idle after done", {31'd0, busy}, 32'd0);
         end
      end

      // reset in the middle of a 16x16 draw: rows 0 and 1 complete, row 2 not yet written
      for (int j = 0; j < 32; j++) rom[j] = (j % 2 == 0) ? 8'hFF : 8'h00;
      @(negedge clk);
      clr_fb = 1'b1; clr_cnt = 1'b1;
      @(negedge clk);
      clr_fb = 1'b0; clr_cnt = 1'b0;
      pos_x = 7'd0; pos_y = 6'd0; rows = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset fbuf_en", {31'd0, fbuf_en}, 32'd0);
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset spr_rd", {31'd0, spr_rd}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midreset writes", n_wr, 2);
      check("midreset idle fbuf_en", {31'd0, fbuf_en}, 32'd0);
      check("midreset row0 kept", {16'd0, fb_mem[0]}, 32'h0000FF00);
      check("midreset row1 kept", {16'd0, fb_mem[8]}, 32'h0000FF00);
      check("midreset row2 blank", {16'd0, fb_mem[16]}, 32'd0);
      $display("midreset: writes=%0d busy=%0b", n_wr, busy);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
